// File: rtl/lcd_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bus_monitor
// Purpose  : Passive mirror of an HD44780-style character LCD parallel bus.
//            Samples E/RS/RW/DATA through a 2-stage synchronizer and treats
//            each falling edge of the synchronized E as one transaction.
//            Instruction writes update the address counter and display state.
//            Data writes land in a shadow copy of the two visible 16-char
//            lines.
// Ports    :
//   clk          system clock (same clock as the LCD controller)
//   rst          asynchronous reset, active-low
//   LCD_E        enable strobe, asynchronous to clk
//   LCD_RS       0 = instruction, 1 = data
//   LCD_RW       0 = write, 1 = read (reads are ignored)
//   LCD_DATA     bus data byte
//   o_line1      visible line 1, char 0 in [127:120], char 15 in [7:0]
//   o_line2      visible line 2, same packing
//   o_addr       DDRAM address counter (AC)
//   o_inc        entry-mode direction, 1 = increment
//   o_disp_on    display-on bit from the last Display On/Off instruction
//   o_init_done  sticky flag, set by Function Set with DL=1 and N=1
//   o_frame_done one-clock pulse when a data write to address 0x4F commits
// Revision : 1.0 - initial release
// ============================================================================
module lcd_bus_monitor #(
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [7:0]   LCD_DATA,
  output logic [127:0] o_line1,
  output logic [127:0] o_line2,
  output logic [6:0]   o_addr,
  output logic         o_inc,
  output logic         o_disp_on,
  output logic         o_init_done,
  output logic         o_frame_done
);

  // Bus layout inside the synchronizer: {E, RS, RW, DATA[7:0]}
  localparam int BUS_W = 11;

  // --------------------------------------------------------------------------
  // Input synchronizer and falling-edge detector.
  // All bus signals share the same two stages so the RS/RW/DATA used for a
  // transaction are the values captured alongside the synchronized E.
  // --------------------------------------------------------------------------
  logic [BUS_W-1:0] bus_s1;
  logic [BUS_W-1:0] bus_s2;
  logic             e_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_s1 <= '0;
      bus_s2 <= '0;
      e_prev <= 1'b0;
    end else begin
      bus_s1 <= {LCD_E, LCD_RS, LCD_RW, LCD_DATA};
      bus_s2 <= bus_s1;
      e_prev <= bus_s2[10];
    end
  end

  logic       e_sync;
  logic       rs_sync;
  logic       rw_sync;
  logic [7:0] data_sync;
  logic       e_fall;
  logic       wr_instr;
  logic       wr_data;

  assign e_sync    = bus_s2[10];
  assign rs_sync   = bus_s2[9];
  assign rw_sync   = bus_s2[8];
  assign data_sync = bus_s2[7:0];

  // A transaction is prev=1, now=0. Read cycles never change state.
  assign e_fall   = e_prev & ~e_sync;
  assign wr_instr = e_fall & ~rw_sync & ~rs_sync;
  assign wr_data  = e_fall & ~rw_sync &  rs_sync;

  // --------------------------------------------------------------------------
  // Address counter movement on the 2-line DDRAM map.
  // Line 1 occupies 0x00-0x27 and line 2 0x40-0x67; stepping off the end of
  // one line lands on the start of the other. Addresses in the holes
  // (0x28-0x3F, 0x68-0x7F) just step by one with 7-bit wrap.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] nxt;
    if (up) begin
      if (ac == 7'h27)      nxt = 7'h40;
      else if (ac == 7'h67) nxt = 7'h00;
      else                  nxt = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      nxt = 7'h67;
      else if (ac == 7'h40) nxt = 7'h27;
      else                  nxt = ac - 7'd1;
    end
    return nxt;
  endfunction

  // --------------------------------------------------------------------------
  // Shadow state
  // --------------------------------------------------------------------------
  logic [7:0] line1 [16];
  logic [7:0] line2 [16];
  logic [6:0] ac;
  logic       inc_mode;
  logic       disp_on;
  logic       init_done;
  logic       frame_done;

  // Only the first 16 columns of each line are visible and mirrored.
  logic       hit_line1;
  logic       hit_line2;
  logic [3:0] col;

  assign hit_line1 = (ac[6:4] == 3'b000);
  assign hit_line2 = (ac[6:4] == 3'b100);
  assign col       = ac[3:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        line1[i] <= BLANK;
        line2[i] <= BLANK;
      end
      ac         <= 7'h00;
      inc_mode   <= 1'b1;
      disp_on    <= 1'b0;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (wr_data) begin
        if (hit_line1) line1[col] <= data_sync;
        else if (hit_line2) line2[col] <= data_sync;
        // 0x4F is the last visible cell of line 2: a full screen refresh
        // written in increment mode ends here.
        if (ac == 7'h4F) frame_done <= 1'b1;
        ac <= ac_step(ac, inc_mode);
      end

      if (wr_instr) begin
        // Highest set bit selects the instruction.
        casez (data_sync)
          8'b1???????: ac <= data_sync[6:0];
          8'b01??????: ;  // CGRAM address: not mirrored
          8'b001?????: begin
            if (data_sync[4] && data_sync[3]) init_done <= 1'b1;
          end
          8'b0001????: ;  // cursor/display shift: not mirrored
          8'b00001???: disp_on  <= data_sync[2];
          8'b000001??: inc_mode <= data_sync[1];
          8'b0000001?: ac       <= 7'h00;
          8'b00000001: begin
            for (int i = 0; i < 16; i++) begin
              line1[i] <= BLANK;
              line2[i] <= BLANK;
            end
            ac       <= 7'h00;
            inc_mode <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output packing: char 0 in the most significant byte.
  // --------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < 16; g++) begin : g_pack
      assign o_line1[127-8*g -: 8] = line1[g];
      assign o_line2[127-8*g -: 8] = line2[g];
    end
  endgenerate

  assign o_addr       = ac;
  assign o_inc        = inc_mode;
  assign o_disp_on    = disp_on;
  assign o_init_done  = init_done;
  assign o_frame_done = frame_done;

endmodule
`default_nettype wire
